// File: rtl/calc_key_sequencer.sv
// Keypad-to-ALU sequencer for the calculator: builds two decimal operands and an
// operator from key strobes, fires the ALU on EQUALS and holds the result for display.
module calc_key_sequencer #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [15:0]      alu_op,
    input  logic [WIDTH-1:0] alu_r,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             error,
    output logic             busy,
    output logic [WIDTH-1:0] display
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    localparam logic [3:0] KEY_CLEAR  = 4'd10;
    localparam logic [3:0] KEY_ADD    = 4'd11;
    localparam logic [3:0] KEY_DIV    = 4'd14;
    localparam logic [3:0] KEY_EQUALS = 4'd15;

    typedef enum logic [2:0] {
        ST_ENTER_A,
        ST_ENTER_B,
        ST_EXEC,
        ST_SHOW,
        ST_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] display_q, display_d;
    logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
    logic [CNT_W-1:0] b_cnt_q, b_cnt_d;
    logic             result_valid_q, result_valid_d;
    logic             error_q, error_d;
    logic             busy_q, busy_d;

    logic [2*WIDTH-1:0] a_wide, b_wide;
    logic               a_ok, b_ok;
    logic               is_digit, is_op, is_clear, is_equals;

    // Shift-in one decimal digit at double width so overflow is visible in the top half.
    function automatic logic [2*WIDTH-1:0] shift_digit(input logic [WIDTH-1:0] acc,
                                                       input logic [3:0]       digit);
        logic [2*WIDTH-1:0] acc_w;
        acc_w = {{WIDTH{1'b0}}, acc};
        return acc_w * (2*WIDTH)'(10) + (2*WIDTH)'(digit);
    endfunction

    function automatic logic digit_fits(input logic [2*WIDTH-1:0] acc_next,
                                        input logic [CNT_W-1:0]   cnt);
        return (cnt < CNT_W'(MAX_DIGITS)) && (acc_next[2*WIDTH-1:WIDTH] == '0);
    endfunction

    always_comb begin
        is_digit  = (key_code <= 4'd9);
        is_op     = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
        is_clear  = (key_code == KEY_CLEAR);
        is_equals = (key_code == KEY_EQUALS);
        a_wide    = shift_digit(a_q, key_code);
        b_wide    = shift_digit(b_q, key_code);
        a_ok      = digit_fits(a_wide, a_cnt_q);
        b_ok      = digit_fits(b_wide, b_cnt_q);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        a_cnt_d  = a_cnt_q;
        b_cnt_d  = b_cnt_q;

        if (key_valid && is_clear && state_q != ST_EXEC) begin
            state_d  = ST_ENTER_A;
            a_d      = '0;
            b_d      = '0;
            op_d     = '0;
            result_d = '0;
            a_cnt_d  = '0;
            b_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_ENTER_A: begin
                    if (key_valid && is_digit && a_ok) begin
                        a_d     = a_wide[WIDTH-1:0];
                        a_cnt_d = a_cnt_q + CNT_W'(1);
                    end else if (key_valid && is_op) begin
                        op_d    = key_code;
                        b_d     = '0;
                        b_cnt_d = '0;
                        state_d = ST_ENTER_B;
                    end
                end
                ST_ENTER_B: begin
                    if (key_valid && is_digit && b_ok) begin
                        b_d     = b_wide[WIDTH-1:0];
                        b_cnt_d = b_cnt_q + CNT_W'(1);
                    end else if (key_valid && is_op && b_cnt_q == '0) begin
                        op_d = key_code;
                    end else if (key_valid && is_equals && b_cnt_q != '0) begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_q == KEY_DIV && b_q == '0) begin
                        state_d = ST_ERR;
                    end else begin
                        result_d = alu_r;
                        state_d  = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (key_valid && is_digit) begin
                        a_d     = WIDTH'(key_code);
                        a_cnt_d = CNT_W'(1);
                        b_d     = '0;
                        b_cnt_d = '0;
                        state_d = ST_ENTER_A;
                    end else if (key_valid && is_op) begin
                        // Chained operation: the shown result becomes operand A.
                        a_d     = result_q;
                        a_cnt_d = '0;
                        b_d     = '0;
                        b_cnt_d = '0;
                        op_d    = key_code;
                        state_d = ST_ENTER_B;
                    end
                end
                ST_ERR: begin
                end
                default: state_d = ST_ENTER_A;
            endcase
        end

        case (state_d)
            ST_ENTER_A: display_d = a_d;
            ST_ENTER_B: display_d = (b_cnt_d != '0) ? b_d : a_d;
            ST_EXEC:    display_d = a_d;
            ST_SHOW:    display_d = result_d;
            ST_ERR:     display_d = '1;
            default:    display_d = '0;
        endcase

        result_valid_d = (state_d == ST_SHOW);
        error_d        = (state_d == ST_ERR);
        busy_d         = (state_d == ST_EXEC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_ENTER_A;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            result_q       <= '0;
            display_q      <= '0;
            a_cnt_q        <= '0;
            b_cnt_q        <= '0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            result_q       <= result_d;
            display_q      <= display_d;
            a_cnt_q        <= a_cnt_d;
            b_cnt_q        <= b_cnt_d;
            result_valid_q <= result_valid_d;
            error_q        <= error_d;
            busy_q         <= busy_d;
        end
    end

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_op       = {12'b0, op_q};
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign error        = error_q;
    assign busy         = busy_q;
    assign display      = display_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer with a behavioural ALU on alu_r.
module tb_calc_key_sequencer;

    localparam logic [3:0] K_CLR = 4'd10;
    localparam logic [3:0] K_ADD = 4'd11;
    localparam logic [3:0] K_SUB = 4'd12;
    localparam logic [3:0] K_MUL = 4'd13;
    localparam logic [3:0] K_DIV = 4'd14;
    localparam logic [3:0] K_EQ  = 4'd15;

    logic        clk;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] alu_a, alu_b, alu_op, alu_r, result, display;
    logic        result_valid, error, busy;

    int n_checks = 0;
    int n_fail   = 0;

    calc_key_sequencer #(.WIDTH(16), .MAX_DIGITS(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_r        (alu_r),
        .result       (result),
        .result_valid (result_valid),
        .error        (error),
        .busy         (busy),
        .display      (display)
    );

    always_comb begin
        alu_r = 16'h0000;
        case (alu_op)
            16'd11: alu_r = alu_a + alu_b;
            16'd12: alu_r = alu_a - alu_b;
            16'd13: alu_r = alu_a * alu_b;
            16'd14: alu_r = (alu_b == 16'd0) ? 16'd0 : alu_a / alu_b;
            default: alu_r = 16'h0000;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        kv;
        logic [3:0]  key;
        logic [15:0] a, b, op, res, disp;
        logic        rv, err, busy;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic r, input logic kv, input logic [3:0] k,
                     input logic [15:0] a, input logic [15:0] b, input logic [15:0] op,
                     input logic [15:0] res, input logic [15:0] disp,
                     input logic rv, input logic err, input logic bsy);
        vec_t t;
        t.rst = r; t.kv = kv; t.key = k;
        t.a = a; t.b = b; t.op = op; t.res = res; t.disp = disp;
        t.rv = rv; t.err = err; t.busy = bsy;
        vecs.push_back(t);
    endtask

    task automatic step(input logic r, input logic kv, input logic [3:0] k);
        @(negedge clk);
        rst       = r;
        key_valid = kv;
        key_code  = k;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [15:0] a, input logic [15:0] b, input logic [15:0] op,
                         input logic [15:0] res, input logic [15:0] disp,
                         input logic rv, input logic err, input logic bsy);
        n_checks++;
        if ({alu_a, alu_b, alu_op, result, display, result_valid, error, busy} !==
            {a, b, op, res, disp, rv, err, bsy}) begin
            n_fail++;
            $display("FAIL %s: got a=%h b=%h op=%0d res=%h disp=%h rv=%b err=%b busy=%b, required a=%h b=%h op=%0d res=%h disp=%h rv=%b err=%b busy=%b",
                     name, alu_a, alu_b, alu_op, result, display, result_valid, error, busy,
                     a, b, op, res, disp, rv, err, bsy);
        end
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;

        // reset overrides a key in the same cycle
        v(1,1,4'd5,    16'd0,16'd0,16'd0,16'd0,16'd0, 0,0,0);
        // 12 + 34
        v(0,1,4'd1,    16'd1,16'd0,16'd0,16'd0,16'd1, 0,0,0);
        v(0,1,4'd2,    16'd12,16'd0,16'd0,16'd0,16'd12, 0,0,0);
        v(0,1,K_ADD,   16'd12,16'd0,16'd11,16'd0,16'd12, 0,0,0);
        v(0,1,4'd3,    16'd12,16'd3,16'd11,16'd0,16'd3, 0,0,0);
        v(0,1,4'd4,    16'd12,16'd34,16'd11,16'd0,16'd34, 0,0,0);
        v(0,1,K_EQ,    16'd12,16'd34,16'd11,16'd0,16'd12, 0,0,1);
        v(0,0,4'd0,    16'd12,16'd34,16'd11,16'd46,16'd46, 1,0,0);
        // 7 - 9 wraps, then chained * 2
        v(0,1,4'd7,    16'd7,16'd0,16'd11,16'd46,16'd7, 0,0,0);
        v(0,1,K_SUB,   16'd7,16'd0,16'd12,16'd46,16'd7, 0,0,0);
        v(0,1,4'd9,    16'd7,16'd9,16'd12,16'd46,16'd9, 0,0,0);
        v(0,1,K_EQ,    16'd7,16'd9,16'd12,16'd46,16'd7, 0,0,1);
        v(0,0,4'd0,    16'd7,16'd9,16'd12,16'hFFFE,16'hFFFE, 1,0,0);
        v(0,1,K_MUL,   16'hFFFE,16'd0,16'd13,16'hFFFE,16'hFFFE, 0,0,0);
        v(0,1,4'd2,    16'hFFFE,16'd2,16'd13,16'hFFFE,16'd2, 0,0,0);
        v(0,1,K_EQ,    16'hFFFE,16'd2,16'd13,16'hFFFE,16'hFFFE, 0,0,1);
        v(0,0,4'd0,    16'hFFFE,16'd2,16'd13,16'hFFFC,16'hFFFC, 1,0,0);
        // divide by zero, ERR sticks until CLEAR
        v(0,1,K_CLR,   16'd0,16'd0,16'd0,16'd0,16'd0, 0,0,0);
        v(0,1,K_EQ,    16'd0,16'd0,16'd0,16'd0,16'd0, 0,0,0);
        v(0,1,4'd1,    16'd1,16'd0,16'd0,16'd0,16'd1, 0,0,0);
        v(0,1,4'd0,    16'd10,16'd0,16'd0,16'd0,16'd10, 0,0,0);
        v(0,1,4'd0,    16'd100,16'd0,16'd0,16'd0,16'd100, 0,0,0);
        v(0,1,K_DIV,   16'd100,16'd0,16'd14,16'd0,16'd100, 0,0,0);
        v(0,1,4'd0,    16'd100,16'd0,16'd14,16'd0,16'd0, 0,0,0);
        v(0,1,K_EQ,    16'd100,16'd0,16'd14,16'd0,16'd100, 0,0,1);
        v(0,0,4'd0,    16'd100,16'd0,16'd14,16'd0,16'hFFFF, 0,1,0);
        v(0,1,4'd5,    16'd100,16'd0,16'd14,16'd0,16'hFFFF, 0,1,0);
        v(0,1,K_EQ,    16'd100,16'd0,16'd14,16'd0,16'hFFFF, 0,1,0);
        v(0,1,K_ADD,   16'd100,16'd0,16'd14,16'd0,16'hFFFF, 0,1,0);
        v(0,1,K_CLR,   16'd0,16'd0,16'd0,16'd0,16'd0, 0,0,0);
        // overflow rejection and digit-count limit
        v(0,1,4'd6,    16'd6,16'd0,16'd0,16'd0,16'd6, 0,0,0);
        v(0,1,4'd5,    16'd65,16'd0,16'd0,16'd0,16'd65, 0,0,0);
        v(0,1,4'd5,    16'd655,16'd0,16'd0,16'd0,16'd655, 0,0,0);
        v(0,1,4'd3,    16'd6553,16'd0,16'd0,16'd0,16'd6553, 0,0,0);
        v(0,1,4'd6,    16'd6553,16'd0,16'd0,16'd0,16'd6553, 0,0,0);
        v(0,1,K_CLR,   16'd0,16'd0,16'd0,16'd0,16'd0, 0,0,0);
        v(0,1,4'd6,    16'd6,16'd0,16'd0,16'd0,16'd6, 0,0,0);
        v(0,1,4'd5,    16'd65,16'd0,16'd0,16'd0,16'd65, 0,0,0);
        v(0,1,4'd5,    16'd655,16'd0,16'd0,16'd0,16'd655, 0,0,0);
        v(0,1,4'd3,    16'd6553,16'd0,16'd0,16'd0,16'd6553, 0,0,0);
        v(0,1,4'd5,    16'd65535,16'd0,16'd0,16'd0,16'd65535, 0,0,0);
        v(0,1,K_CLR,   16'd0,16'd0,16'd0,16'd0,16'd0, 0,0,0);
        v(0,1,4'd0,    16'd0,16'd0,16'd0,16'd0,16'd0, 0,0,0);
        v(0,1,4'd0,    16'd0,16'd0,16'd0,16'd0,16'd0, 0,0,0);
        v(0,1,4'd1,    16'd1,16'd0,16'd0,16'd0,16'd1, 0,0,0);
        v(0,1,4'd2,    16'd12,16'd0,16'd0,16'd0,16'd12, 0,0,0);
        v(0,1,4'd3,    16'd123,16'd0,16'd0,16'd0,16'd123, 0,0,0);
        v(0,1,4'd4,    16'd123,16'd0,16'd0,16'd0,16'd123, 0,0,0);
        v(0,0,4'd7,    16'd123,16'd0,16'd0,16'd0,16'd123, 0,0,0);
        // operator replacement with no B digits, EQUALS needs a B digit
        v(0,1,K_CLR,   16'd0,16'd0,16'd0,16'd0,16'd0, 0,0,0);
        v(0,1,4'd8,    16'd8,16'd0,16'd0,16'd0,16'd8, 0,0,0);
        v(0,1,K_ADD,   16'd8,16'd0,16'd11,16'd0,16'd8, 0,0,0);
        v(0,1,K_SUB,   16'd8,16'd0,16'd12,16'd0,16'd8, 0,0,0);
        v(0,1,K_MUL,   16'd8,16'd0,16'd13,16'd0,16'd8, 0,0,0);
        v(0,1,K_EQ,    16'd8,16'd0,16'd13,16'd0,16'd8, 0,0,0);
        v(0,0,4'd0,    16'd8,16'd0,16'd13,16'd0,16'd8, 0,0,0);
        v(0,1,4'd4,    16'd8,16'd4,16'd13,16'd0,16'd4, 0,0,0);
        v(0,1,K_ADD,   16'd8,16'd4,16'd13,16'd0,16'd4, 0,0,0);
        v(0,1,K_EQ,    16'd8,16'd4,16'd13,16'd0,16'd8, 0,0,1);
        v(0,0,4'd0,    16'd8,16'd4,16'd13,16'd32,16'd32, 1,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].kv, vecs[i].key);
            check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                  vecs[i].res, vecs[i].disp, vecs[i].rv, vecs[i].err, vecs[i].busy);
        end

        // CLEAR during EXEC is ignored; result still lands
        step(0, 1, K_CLR);
        step(0, 1, 4'd2);
        step(0, 1, K_ADD);
        step(0, 1, 4'd3);
        step(0, 1, K_EQ);
        check("exec_entry", 16'd2, 16'd3, 16'd11, 16'd0, 16'd2, 0, 0, 1);
        step(0, 1, K_CLR);
        check("exec_ignores_clear", 16'd2, 16'd3, 16'd11, 16'd5, 16'd5, 1, 0, 0);

        // reset during EXEC wins over the pending capture
        step(0, 1, 4'd9);
        step(0, 1, K_ADD);
        step(0, 1, 4'd1);
        step(0, 1, K_EQ);
        check("exec_before_rst", 16'd9, 16'd1, 16'd11, 16'd5, 16'd9, 0, 0, 1);
        step(1, 1, K_EQ);
        check("rst_in_exec", 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 0, 0, 0);
        step(0, 1, 4'd3);
        check("after_rst_digit", 16'd3, 16'd0, 16'd0, 16'd0, 16'd3, 0, 0, 0);

        key_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
